// File: rtl/zero_pattern_gen_pkg.sv
// Shared constants for the zero-pattern stimulus generator: state codes,
// default sizes and the count-field width derivation.
package zero_pattern_gen_pkg;

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_RUN  = 1'b1;

    localparam int DEFAULT_WIDTH = 8;
    localparam int DEFAULT_LW    = 8;

    // The count field must be able to represent WIDTH itself (all-zero word).
    function automatic int count_width(input int width);
        return $clog2(width + 1);
    endfunction

endpackage

// File: rtl/zero_pattern_gen.sv
// Emits a stream of words, each carrying exactly the requested number of zero
// bits, by rotating a base pattern; valid/ready on the output side.
module zero_pattern_gen
    import zero_pattern_gen_pkg::*;
#(
    parameter  int WIDTH = DEFAULT_WIDTH,
    parameter  int LW    = DEFAULT_LW,
    localparam int CW    = count_width(WIDTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [CW-1:0]    req_count,
    input  logic [LW-1:0]    req_len,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic             out_last,
    output logic             err,
    output logic             busy
);

    localparam logic [CW-1:0] MAX_COUNT = CW'(WIDTH);
    localparam logic [LW-1:0] ONE_LEFT  = LW'(1);

    logic [0:0]       state_reg;
    logic [WIDTH-1:0] data_reg;
    logic [LW-1:0]    remaining_reg;
    logic             err_reg;

    logic accept;
    logic legal;
    logic beat_done;

    assign accept    = req_valid && (state_reg == ST_IDLE);
    assign legal     = (req_count <= MAX_COUNT) && (req_len != '0);
    assign beat_done = (state_reg == ST_RUN) && out_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg     <= ST_IDLE;
            data_reg      <= '0;
            remaining_reg <= '0;
            err_reg       <= 1'b0;
        end else begin
            err_reg <= accept && !legal;
            if (accept && legal) begin
                state_reg     <= ST_RUN;
                // Shifting by WIDTH yields the all-zero word.
                data_reg      <= {WIDTH{1'b1}} << req_count;
                remaining_reg <= req_len;
            end else if (beat_done) begin
                if (remaining_reg == ONE_LEFT) begin
                    // out_data keeps the final beat; only the handshake drops.
                    state_reg     <= ST_IDLE;
                    remaining_reg <= '0;
                end else begin
                    data_reg      <= {data_reg[WIDTH-2:0], data_reg[WIDTH-1]};
                    remaining_reg <= remaining_reg - ONE_LEFT;
                end
            end
        end
    end

    assign req_ready = (state_reg == ST_IDLE);
    assign busy      = (state_reg == ST_RUN);
    assign out_valid = busy;
    assign out_last  = out_valid && (remaining_reg == ONE_LEFT);
    assign out_data  = data_reg;
    assign err       = err_reg;

endmodule

// File: tb/tb_zero_pattern_gen.sv
// Directed bench for zero_pattern_gen: hand-computed beat sequences, zero-count
// scoreboard, illegal requests, backpressure, wraparound and async reset.
module tb_zero_pattern_gen;

    localparam int WIDTH = 8;
    localparam int LW    = 8;
    localparam int CW    = 4;

    logic             clk;
    logic             rst_n;
    logic             req_valid;
    logic             req_ready;
    logic [CW-1:0]    req_count;
    logic [LW-1:0]    req_len;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_data;
    logic             out_last;
    logic             err;
    logic             busy;

    int errors = 0;
    int checks = 0;

    zero_pattern_gen #(.WIDTH(WIDTH), .LW(LW)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_count (req_count),
        .req_len   (req_len),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_last  (out_last),
        .err       (err),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic int count_zeros(input logic [WIDTH-1:0] w);
        int n = 0;
        for (int b = 0; b < WIDTH; b++) if (w[b] == 1'b0) n++;
        return n;
    endfunction

    // Presents a request for one edge; returns at the negedge where the
    // first beat (or err pulse) is visible.
    task automatic send_req(input logic [CW-1:0] c, input logic [LW-1:0] l);
        req_valid = 1'b1;
        req_count = c;
        req_len   = l;
        @(negedge clk);
        req_valid = 1'b0;
        $display("req count=%0d len=%0d", c, l);
    endtask

    task automatic test_reset;
        rst_n = 1'b0; req_valid = 1'b0; req_count = '0; req_len = '0; out_ready = 1'b1;
        repeat (2) @(negedge clk);
        checks++;
        if ({req_ready, out_valid, out_data, out_last, err, busy} !== {1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0}) begin
            errors++;
            $display("FAIL reset: rdy=%b vld=%b data=%h last=%b err=%b busy=%b, required rdy=1 vld=0 data=00 last=0 err=0 busy=0",
                     req_ready, out_valid, out_data, out_last, err, busy);
        end
        rst_n = 1'b1;
        @(negedge clk);
        $display("reset released");
    endtask

    task automatic test_basic;
        logic [WIDTH-1:0] exp_d [4] = '{8'hF8, 8'hF1, 8'hE3, 8'hC7};
        out_ready = 1'b1;
        send_req(4'd3, 8'd4);
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (out_valid !== 1'b1 || out_data !== exp_d[i] || out_last !== (i == 3)) begin
                errors++;
                $display("FAIL basic_beat%0d: vld=%b data=%h last=%b, required vld=1 data=%h last=%b",
                         i, out_valid, out_data, out_last, exp_d[i], (i == 3));
            end
            checks++;
            if (count_zeros(out_data) != 3) begin
                errors++;
                $display("FAIL basic_zeros%0d: zeros=%0d, required 3", i, count_zeros(out_data));
            end
            $display("basic beat %0d data=%h last=%b", i, out_data, out_last);
            @(negedge clk);
        end
        checks++;
        if (out_valid !== 1'b0 || req_ready !== 1'b1 || busy !== 1'b0 || out_data !== 8'hC7) begin
            errors++;
            $display("FAIL basic_end: vld=%b rdy=%b busy=%b data=%h, required vld=0 rdy=1 busy=0 data=c7",
                     out_valid, req_ready, busy, out_data);
        end
    endtask

    task automatic test_extremes;
        out_ready = 1'b1;
        send_req(4'd0, 8'd2);
        for (int i = 0; i < 2; i++) begin
            checks++;
            if (out_valid !== 1'b1 || out_data !== 8'hFF || out_last !== (i == 1)) begin
                errors++;
                $display("FAIL count0_beat%0d: vld=%b data=%h last=%b, required vld=1 data=ff last=%b",
                         i, out_valid, out_data, out_last, (i == 1));
            end
            $display("count0 beat %0d data=%h", i, out_data);
            @(negedge clk);
        end
        send_req(4'd8, 8'd1);
        checks++;
        if (out_valid !== 1'b1 || out_data !== 8'h00 || out_last !== 1'b1) begin
            errors++;
            $display("FAIL count8_beat: vld=%b data=%h last=%b, required vld=1 data=00 last=1",
                     out_valid, out_data, out_last);
        end
        @(negedge clk);
        checks++;
        if (out_valid !== 1'b0 || out_last !== 1'b0) begin
            errors++;
            $display("FAIL count8_end: vld=%b last=%b, required vld=0 last=0", out_valid, out_last);
        end
    endtask

    task automatic test_illegal;
        logic [CW-1:0] bad_c [2] = '{4'd9, 4'd2};
        logic [LW-1:0] bad_l [2] = '{8'd1, 8'd0};
        for (int k = 0; k < 2; k++) begin
            send_req(bad_c[k], bad_l[k]);
            checks++;
            if (err !== 1'b1 || out_valid !== 1'b0 || req_ready !== 1'b1) begin
                errors++;
                $display("FAIL illegal%0d_pulse: err=%b vld=%b rdy=%b, required err=1 vld=0 rdy=1",
                         k, err, out_valid, req_ready);
            end
            @(negedge clk);
            checks++;
            if (err !== 1'b0 || out_valid !== 1'b0 || req_ready !== 1'b1) begin
                errors++;
                $display("FAIL illegal%0d_after: err=%b vld=%b rdy=%b, required err=0 vld=0 rdy=1",
                         k, err, out_valid, req_ready);
            end
        end
    endtask

    task automatic test_backpressure;
        out_ready = 1'b0;
        send_req(4'd1, 8'd3);
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (out_valid !== 1'b1 || out_data !== 8'hFE || out_last !== 1'b0) begin
                errors++;
                $display("FAIL stall%0d: vld=%b data=%h last=%b, required vld=1 data=fe last=0",
                         i, out_valid, out_data, out_last);
            end
            $display("stall cycle %0d data=%h", i, out_data);
            if (i == 3) out_ready = 1'b1;
            @(negedge clk);
        end
        checks++;
        if (out_data !== 8'hFD || out_last !== 1'b0) begin
            errors++;
            $display("FAIL stall_beat2: data=%h last=%b, required data=fd last=0", out_data, out_last);
        end
        @(negedge clk);
        checks++;
        if (out_data !== 8'hFB || out_last !== 1'b1 || out_valid !== 1'b1) begin
            errors++;
            $display("FAIL stall_beat3: vld=%b data=%h last=%b, required vld=1 data=fb last=1",
                     out_valid, out_data, out_last);
        end
        @(negedge clk);
    endtask

    task automatic test_long;
        logic [WIDTH-1:0] exp_d [10] = '{8'hFC, 8'hF9, 8'hF3, 8'hE7, 8'hCF,
                                         8'h9F, 8'h3F, 8'h7E, 8'hFC, 8'hF9};
        out_ready = 1'b1;
        send_req(4'd2, 8'd10);
        for (int i = 0; i < 10; i++) begin
            checks++;
            if (out_valid !== 1'b1 || out_data !== exp_d[i] || out_last !== (i == 9)
                || count_zeros(out_data) != 2) begin
                errors++;
                $display("FAIL long_beat%0d: vld=%b data=%h last=%b zeros=%0d, required vld=1 data=%h last=%b zeros=2",
                         i, out_valid, out_data, out_last, count_zeros(out_data), exp_d[i], (i == 9));
            end
            $display("long beat %0d data=%h", i, out_data);
            @(negedge clk);
        end
        checks++;
        if (out_valid !== 1'b0) begin
            errors++;
            $display("FAIL long_extra: vld=%b, required 0", out_valid);
        end
    endtask

    task automatic test_back_to_back;
        out_ready = 1'b1;
        req_valid = 1'b1; req_count = 4'd3; req_len = 8'd1;
        @(negedge clk);
        req_count = 4'd0; req_len = 8'd1;  // held request for the next stream
        checks++;
        if (out_valid !== 1'b1 || out_data !== 8'hF8 || out_last !== 1'b1) begin
            errors++;
            $display("FAIL b2b_first: vld=%b data=%h last=%b, required vld=1 data=f8 last=1",
                     out_valid, out_data, out_last);
        end
        @(negedge clk);
        checks++;
        if (out_valid !== 1'b0 || req_ready !== 1'b1 || busy !== 1'b0) begin
            errors++;
            $display("FAIL b2b_gap: vld=%b rdy=%b busy=%b, required vld=0 rdy=1 busy=0",
                     out_valid, req_ready, busy);
        end
        @(negedge clk);
        req_valid = 1'b0;
        checks++;
        if (out_valid !== 1'b1 || out_data !== 8'hFF || out_last !== 1'b1) begin
            errors++;
            $display("FAIL b2b_second: vld=%b data=%h last=%b, required vld=1 data=ff last=1",
                     out_valid, out_data, out_last);
        end
        $display("back-to-back second data=%h", out_data);
        @(negedge clk);
    endtask

    task automatic test_async_reset;
        out_ready = 1'b1;
        send_req(4'd4, 8'd5);
        repeat (2) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if (out_valid !== 1'b0 || busy !== 1'b0 || out_last !== 1'b0 || req_ready !== 1'b1) begin
            errors++;
            $display("FAIL async_reset: vld=%b busy=%b last=%b rdy=%b, required vld=0 busy=0 last=0 rdy=1",
                     out_valid, busy, out_last, req_ready);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        send_req(4'd4, 8'd2);
        checks++;
        if (out_valid !== 1'b1 || out_data !== 8'hF0 || out_last !== 1'b0) begin
            errors++;
            $display("FAIL post_reset_beat1: vld=%b data=%h last=%b, required vld=1 data=f0 last=0",
                     out_valid, out_data, out_last);
        end
        @(negedge clk);
        checks++;
        if (out_valid !== 1'b1 || out_data !== 8'hE1 || out_last !== 1'b1) begin
            errors++;
            $display("FAIL post_reset_beat2: vld=%b data=%h last=%b, required vld=1 data=e1 last=1",
                     out_valid, out_data, out_last);
        end
        @(negedge clk);
        $display("post-reset stream done");
    endtask

    initial begin
        test_reset();
        test_basic();
        test_extremes();
        test_illegal();
        test_backpressure();
        test_long();
        test_back_to_back();
        test_async_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
